// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the clock-gate controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    GS_RUN   = 2'd0,
    GS_GATED = 2'd1,
    GS_WAKE  = 2'd2
  } gate_state_e;

  localparam int unsigned STATS_W = 32;

endpackage

// File: rtl/gate_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module gate_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clr) begin
      w_cnt_d = '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      w_cnt_d = r_cnt + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock-enable controller with wake handshake.
// Optional gated-cycle statistics counter enabled by defining CLK_GATE_STATS_EN.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = $clog2(IDLE_CYCLES + WAKE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               activity,
  input  logic               wake_req,
  input  logic               force_on,
  input  logic               stats_clr,
  output logic               clk_en,
  output logic               gated,
  output logic               wake_ack,
  output logic [STATS_W-1:0] gated_cycles
);

  localparam logic [1:0] ST_RUN   = GS_RUN;
  localparam logic [1:0] ST_GATED = GS_GATED;
  localparam logic [1:0] ST_WAKE  = GS_WAKE;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             r_clk_en;
  logic             r_gated;
  logic             r_wake_ack;
  logic             w_idle;

  assign w_idle = !activity && !wake_req && !force_on;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_idle) begin
          if (r_cnt == IDLE_LAST) begin
            w_state_d = ST_GATED;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_d = '0;
        end
      end
      ST_GATED: begin
        if (!w_idle) begin
          w_state_d = ST_WAKE;
          w_cnt_d   = '0;
        end
      end
      // Settle time: inputs are deliberately ignored until the count completes.
      ST_WAKE: begin
        if (r_cnt == WAKE_LAST) begin
          w_state_d = ST_RUN;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_d = ST_RUN;
        w_cnt_d   = '0;
      end
    endcase
  end

  // clk_en resets high so downstream synchronous resets still see clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_clk_en   <= 1'b1;
      r_gated    <= 1'b0;
      r_wake_ack <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_clk_en   <= (w_state_d != ST_GATED);
      r_gated    <= (w_state_d == ST_GATED);
      r_wake_ack <= (r_state == ST_RUN) && wake_req;
    end
  end

  assign clk_en   = r_clk_en;
  assign gated    = r_gated;
  assign wake_ack = r_wake_ack;

`ifdef CLK_GATE_STATS_EN
  logic w_in_gated;
  assign w_in_gated = (r_state == ST_GATED);

  gate_sat_counter #(
    .W(STATS_W)
  ) u_stats (
    .clk  (clk),
    .rst_n(rst_n),
    .i_clr(stats_clr),
    .i_inc(w_in_gated),
    .o_cnt(gated_cycles)
  );
`else
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = stats_clr;
  assign gated_cycles       = '0;
`endif

endmodule
